// File: rtl/ddr_init_pkg.sv
// ddr_init_pkg: shared types and constants for the DDR3 init stages.
//   init_state_e : mode-register / ZQ init sequencer states
//   CMD_*        : DFI command encodings as {cs_n, ras_n, cas_n, we_n}
//   MRx_IDX      : bank address used to select each mode register
package ddr_init_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CKE_WAIT,
    XPR_WAIT,
    MRS2,
    MRD2,
    MRS3,
    MRD3,
    MRS1,
    MRD1,
    MRS0,
    MOD_WAIT,
    ZQCL,
    ZQ_WAIT,
    DONE
  } init_state_e;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;

  localparam logic [2:0] MR0_IDX = 3'd0;
  localparam logic [2:0] MR1_IDX = 3'd1;
  localparam logic [2:0] MR2_IDX = 3'd2;
  localparam logic [2:0] MR3_IDX = 3'd3;

  // Address bit that selects the long ZQ calibration.
  localparam int unsigned ZQ_LONG_BIT = 10;

endpackage

// File: rtl/init_timer.sv
// init_timer: loadable down-counter used to time DDR init intervals.
//   core_clk   : clock
//   core_arstn : asynchronous active-low reset (count -> 0)
//   load       : load load_val this cycle (has priority over dec)
//   dec        : decrement by one; holds at zero, never wraps
//   load_val   : value to load
//   zero       : count is zero
module init_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             core_clk,
  input  logic             core_arstn,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ddr_mrs_init_seq.sv
// ddr_mrs_init_seq: DDR3 power-up second stage. After ddr_init_done it waits
// the CKE enable delay, raises CKE, issues MR2, MR3, MR1, MR0 and ZQCL with
// the configured spacing, then raises seq_done (sticky until reset).
//   core_clk      : clock
//   core_arstn    : asynchronous active-low reset
//   ddr_init_done : reset-hold stage complete (level, sampled in IDLE)
//   seq_done      : init sequence complete
//   dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n : DFI control
//   dfi_bank      : MR index during MRS, else 0
//   dfi_address   : MR payload during MRS, A10 during ZQCL, else 0
module ddr_mrs_init_seq
  import ddr_init_pkg::*;
#(
  parameter int unsigned       CNT_W      = 20,
  parameter int unsigned       T_CKE_WAIT = 400000,
  parameter int unsigned       T_XPR      = 144,
  parameter int unsigned       T_MRD      = 4,
  parameter int unsigned       T_MOD      = 12,
  parameter int unsigned       T_ZQINIT   = 512,
  parameter int unsigned       BA_W       = 3,
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] MR0_VAL    = '0,
  parameter logic [ADDR_W-1:0] MR1_VAL    = '0,
  parameter logic [ADDR_W-1:0] MR2_VAL    = '0,
  parameter logic [ADDR_W-1:0] MR3_VAL    = '0
) (
  input  logic              core_clk,
  input  logic              core_arstn,
  input  logic              ddr_init_done,
  output logic              seq_done,
  output logic              dfi_cke,
  output logic              dfi_cs_n,
  output logic              dfi_ras_n,
  output logic              dfi_cas_n,
  output logic              dfi_we_n,
  output logic [BA_W-1:0]   dfi_bank,
  output logic [ADDR_W-1:0] dfi_address
);

  localparam longint unsigned CNT_LIM = longint'(1) << CNT_W;

  if (T_CKE_WAIT < 2 || T_XPR < 2 || T_MRD < 2 || T_MOD < 2 || T_ZQINIT < 2) begin : g_bad_timing
    $error("ddr_mrs_init_seq: timing parameters must be at least 2");
  end
  if (longint'(T_CKE_WAIT) >= CNT_LIM || longint'(T_XPR) >= CNT_LIM ||
      longint'(T_MRD) >= CNT_LIM || longint'(T_MOD) >= CNT_LIM ||
      longint'(T_ZQINIT) >= CNT_LIM) begin : g_bad_cnt_w
    $error("ddr_mrs_init_seq: timing parameter does not fit in CNT_W");
  end
  if (ADDR_W <= ZQ_LONG_BIT) begin : g_bad_addr_w
    $error("ddr_mrs_init_seq: ADDR_W too narrow for ZQCL A10");
  end

  init_state_e       state, state_nxt;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;
  logic [3:0]        cmd_nxt, cmd_q;
  logic [BA_W-1:0]   bank_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              cke_nxt, done_nxt;

  init_timer #(.CNT_W(CNT_W)) u_timer (
    .core_clk   (core_clk),
    .core_arstn (core_arstn),
    .load       (tmr_load),
    .dec        (tmr_dec),
    .load_val   (tmr_val),
    .zero       (tmr_zero)
  );

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command fields are decoded from the current state and registered, so
  // each command reaches the DFI one cycle after its state. MRS/ZQCL reloads
  // use T-2 because the command state itself and the zero-detect cycle each
  // take one clock of the interval.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    cmd_nxt   = CMD_NOP;
    bank_nxt  = '0;
    addr_nxt  = '0;
    case (state)
      IDLE: begin
        if (ddr_init_done) begin
          state_nxt = CKE_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(T_CKE_WAIT - 1);
        end
      end
      CKE_WAIT: begin
        if (tmr_zero) begin
          state_nxt = XPR_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(T_XPR - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      XPR_WAIT: if (tmr_zero) state_nxt = MRS2; else tmr_dec = 1'b1;
      MRS2, MRS3, MRS1: begin
        cmd_nxt  = CMD_MRS;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_MRD - 2);
        case (state)
          MRS2:    begin bank_nxt = BA_W'(MR2_IDX); addr_nxt = MR2_VAL; state_nxt = MRD2; end
          MRS3:    begin bank_nxt = BA_W'(MR3_IDX); addr_nxt = MR3_VAL; state_nxt = MRD3; end
          default: begin bank_nxt = BA_W'(MR1_IDX); addr_nxt = MR1_VAL; state_nxt = MRD1; end
        endcase
      end
      MRD2: if (tmr_zero) state_nxt = MRS3; else tmr_dec = 1'b1;
      MRD3: if (tmr_zero) state_nxt = MRS1; else tmr_dec = 1'b1;
      MRD1: if (tmr_zero) state_nxt = MRS0; else tmr_dec = 1'b1;
      MRS0: begin
        cmd_nxt   = CMD_MRS;
        bank_nxt  = BA_W'(MR0_IDX);
        addr_nxt  = MR0_VAL;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(T_MOD - 2);
        state_nxt = MOD_WAIT;
      end
      MOD_WAIT: if (tmr_zero) state_nxt = ZQCL; else tmr_dec = 1'b1;
      ZQCL: begin
        cmd_nxt               = CMD_ZQCL;
        addr_nxt[ZQ_LONG_BIT] = 1'b1;
        tmr_load              = 1'b1;
        tmr_val               = CNT_W'(T_ZQINIT - 2);
        state_nxt             = ZQ_WAIT;
      end
      ZQ_WAIT: if (tmr_zero) state_nxt = DONE; else tmr_dec = 1'b1;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    cke_nxt  = !(state inside {IDLE, CKE_WAIT});
    done_nxt = (state == DONE);
    if (!cke_nxt) cmd_nxt = CMD_DESEL;
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      seq_done    <= 1'b0;
      dfi_cke     <= 1'b0;
      cmd_q       <= CMD_DESEL;
      dfi_bank    <= '0;
      dfi_address <= '0;
    end else begin
      seq_done    <= done_nxt;
      dfi_cke     <= cke_nxt;
      cmd_q       <= cmd_nxt;
      dfi_bank    <= bank_nxt;
      dfi_address <= addr_nxt;
    end
  end

  assign {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} = cmd_q;

endmodule

// File: doc/ddr_mrs_init_seq.md
Name: ddr_mrs_init_seq

Overview:
Second stage of DDR3 power-up. It starts once the reset-hold stage reports ddr_init_done, which means dfi_reset_n has been held low for 200 us and then released. This block waits the CKE-enable delay, raises CKE, issues MR2, MR3, MR1, MR0 and ZQCL with the required spacing, then asserts seq_done to the scheduler. All commands leave on the DFI command bus; NOP is driven on every cycle that carries no command.

Parameters:
CNT_W, 20, width of the timing down-counter.
T_CKE_WAIT, 400000, clocks from the start pulse to CKE high (500 us).
T_XPR, 144, clocks from CKE high to the first MRS.
T_MRD, 4, clocks from one MRS to the next MRS.
T_MOD, 12, clocks from MR0 to ZQCL.
T_ZQINIT, 512, clocks from ZQCL to done.
BA_W, 3, bank address width.
ADDR_W, 16, row/column address width.
MR0_VAL / MR1_VAL / MR2_VAL / MR3_VAL, 16'h0000, mode register payloads placed on dfi_address.

Ports:
core_clk  in  1  core clock.
core_arstn  in  1  asynchronous active-low reset.
ddr_init_done  in  1  reset-hold complete; level signal, sampled high to start.
seq_done  out  1  mode-register and ZQ init complete; sticky until reset.
dfi_cke  out  1  clock enable.
dfi_cs_n  out  1  chip select.
dfi_ras_n  out  1  row address strobe.
dfi_cas_n  out  1  column address strobe.
dfi_we_n  out  1  write enable.
dfi_bank  out  BA_W  bank address; carries the MR index during MRS.
dfi_address  out  ADDR_W  address; carries the MR payload during MRS, A10 during ZQCL.

Behaviour:
- Reset values: seq_done=0, dfi_cke=0, dfi_cs_n=1, dfi_ras_n=1, dfi_cas_n=1, dfi_we_n=1, dfi_bank=0, dfi_address=0. State is IDLE and the counter is 0.
- All outputs are registered. A command appears on the cycle after the state that decides it.
- Command encodings as {cs_n, ras_n, cas_n, we_n}:
  - DESEL = 1xxx, driven as 1111.
  - NOP = 0111.
  - MRS = 0000.
  - ZQCL = 0110, with dfi_address[10]=1 and all other address bits 0.
- While dfi_cke=0, drive DESEL. Once dfi_cke=1, every non-command cycle is NOP with bank and address set to 0.
- FSM states: IDLE, CKE_WAIT, XPR_WAIT, MRS2, MRD2, MRS3, MRD3, MRS1, MRD1, MRS0, MOD_WAIT, ZQCL, ZQ_WAIT, DONE.
- IDLE: on ddr_init_done=1, load the counter with T_CKE_WAIT-1 and go to CKE_WAIT. Otherwise stay in IDLE.
- CKE_WAIT: decrement the counter. When it reaches 0, set dfi_cke=1, load T_XPR-1, go to XPR_WAIT.
- XPR_WAIT: when the counter reaches 0, go to MRS2.
- MRSn (one cycle each): issue MRS with dfi_bank=n and dfi_address=MRn_VAL.
  - MRS2, MRS3 and MRS1 each load T_MRD-2 and go to the matching MRDn state, so MRS-to-MRS spacing is exactly T_MRD clocks.
  - MRS0 loads T_MOD-2 and goes to MOD_WAIT.
- MRDn: when the counter reaches 0, go to the next MRS in the order 2, 3, 1, 0.
- MOD_WAIT: when the counter reaches 0, go to ZQCL.
- ZQCL (one cycle): issue ZQCL, load T_ZQINIT-2, go to ZQ_WAIT.
- ZQ_WAIT: when the counter reaches 0, go to DONE and set seq_done=1.
- DONE: terminal; outputs hold NOP with CKE high. Only reset leaves DONE.
- Command spacing: the distance between command cycles equals the parameter exactly. Timing parameters must be at least 2; a value below 2 is a parameter error, flagged by an elaboration-time assertion.
- Counter arithmetic: unsigned, CNT_W bits. A reload always happens in the same cycle as the state change, and the counter never wraps. Every parameter must fit in CNT_W; this is checked by an elaboration-time assertion.
- ddr_init_done falling after the sequence has left IDLE is ignored; the sequence runs to completion.
- Asynchronous reset in any state returns every output to its reset value immediately, including dropping CKE. After reset the block restarts from IDLE.

Decomposition:
- Package ddr_init_pkg holds:
  - the state enum;
  - the 4-bit command constants CMD_DESEL, CMD_NOP, CMD_MRS, CMD_ZQCL;
  - MR index constants.
- One sub-module, init_timer: a loadable CNT_W down-counter with load/value inputs and a zero flag. It is reusable by the reset-hold stage.

Test Plan:
- Hold reset, then release with ddr_init_done=0 for 50 clocks -> CKE=0, cs_n=1 throughout, seq_done=0.
- With T_CKE_WAIT=10, T_XPR=5, T_MRD=4, T_MOD=6, T_ZQINIT=8: raise ddr_init_done at cycle 0 ->
  - CKE rises at cycle 11;
  - MRS appear at cycles 16, 20, 24, 28 with bank 2, 3, 1, 0;
  - ZQCL at cycle 34;
  - seq_done at cycle 42.
- Set MR0_VAL=16'h1D70, MR1_VAL=16'h0044 -> dfi_address equals these values exactly on the MR0 and MR1 command cycles, and is 0 on NOP cycles.
- On the ZQCL cycle -> command 0110, dfi_address=16'h0400, bank 0.
- Pulse ddr_init_done high for 1 cycle, then hold it low -> the full sequence still completes and seq_done stays high for more than 100 cycles.
- Assert core_arstn in MRD3 -> same cycle: CKE=0, cs_n=1, seq_done=0. Release reset with ddr_init_done=1 -> the sequence restarts and the first MRS is bank 2.
